dma2mem_capture_arb: RTL and testbench

Multi-channel capture block for DMA-to-memory traffic, with one channel per PE/lane pair. It snoops each channel's write handshake, and optionally its read-request handshake, and buffers each accepted transaction in a per-channel FIFO. A round-robin arbiter merges the FIFOs into one valid/ready record stream, which feeds the result checker and trace logger. It generalises the single-stream, fixed PE×lane probe to parametrised channel count, widths and depth, and adds buffering, backpressure, overflow status and a drain mode.

---
 rtl/dma2mem_capture_pkg.sv | 23 ++
 rtl/dma2mem_capture_arb_fifo.sv | 42 ++++
 rtl/dma2mem_capture_arb.sv | 145 ++++++++++++++
 tb/tb_dma2mem_capture_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma2mem_capture_pkg.sv
// Shared types and default widths for the DMA-to-memory capture block.
package dma2mem_capture_pkg;

  localparam int NUM_CH_DEF     = 4;
  localparam int ADDR_W_DEF     = 24;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CH_ID_W_DEF    = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [CH_ID_W_DEF-1:0] ch_id;
    logic                   is_write;
    logic [ADDR_W_DEF-1:0]  address;
    logic [DATA_W_DEF-1:0]  data;
  } capture_rec_t;

endpackage

// File: rtl/dma2mem_capture_arb_fifo.sv
// Per-channel single-push/single-pop FIFO; a push into a full FIFO is taken
// only when the head is popped in the same cycle.
module capture_chan_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_poweron,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dma2mem_capture_arb.sv
// Snoops per-channel DMA write/read handshakes into FIFOs and merges them
// round-robin into one registered valid/ready record stream.
module dma2mem_capture_arb
  import dma2mem_capture_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       cfg_enable,
  input  logic                       cfg_capture_reads,
  input  logic                       clear_status,
  input  logic [NUM_CH-1:0]          ch_write_valid,
  input  logic [NUM_CH-1:0]          ch_write_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_write_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
  input  logic [NUM_CH-1:0]          ch_read_valid,
  input  logic [NUM_CH-1:0]          ch_read_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_read_address,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch_id,
  output logic                       out_is_write,
  output logic [ADDR_W-1:0]          out_address,
  output logic [DATA_W-1:0]          out_data,
  output logic [NUM_CH-1:0]          ch_overflow,
  output logic [NUM_CH-1:0]          ch_collision,
  output logic [31:0]                record_count,
  output logic                       drained
);
  localparam int CH_ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W   = 1 + ADDR_W + DATA_W;

  // Channel id is implied by which FIFO holds the entry, so it is not stored.
  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } entry_t;

  cap_state_t        state;
  logic              capturing, out_free, grant, gnt_any, deliver;
  logic [CH_ID_W-1:0] rr_ptr, gnt;
  int                idx;
  logic [NUM_CH-1:0] wr_ev, rd_ev, push, pop, full, empty, ovf_set, col_set;
  entry_t            push_ent [NUM_CH];
  entry_t            head     [NUM_CH];
  entry_t            sel;

  assign capturing = (state == ST_CAPTURE);
  assign deliver   = out_valid & out_ready;
  assign out_free  = ~out_valid | out_ready;
  assign drained   = (state == ST_IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_ev[c] = ch_write_valid[c] & ch_write_ready[c];
    assign rd_ev[c] = ch_read_valid[c] & ch_read_ready[c] & cfg_capture_reads;
    assign push[c]  = capturing & (wr_ev[c] | rd_ev[c]);
    assign push_ent[c] = wr_ev[c]
      ? entry_t'{1'b1, ch_write_address[c*ADDR_W +: ADDR_W], ch_write_data[c*DATA_W +: DATA_W]}
      : entry_t'{1'b0, ch_read_address[c*ADDR_W +: ADDR_W], {DATA_W{1'b0}}};

    capture_chan_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk          (clk),
      .reset_poweron(reset_poweron),
      .push         (push[c]),
      .push_data    (push_ent[c]),
      .pop          (pop[c]),
      .pop_data     (head[c]),
      .full         (full[c]),
      .empty        (empty[c])
    );
  end

  assign ovf_set = push & full & ~pop;
  assign col_set = {NUM_CH{capturing}} & wr_ev & rd_ev;

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!empty[idx]) begin
        gnt_any = 1'b1;
        gnt     = CH_ID_W'(idx);
      end
    end
  end

  assign grant = gnt_any & out_free & (state != ST_IDLE);
  assign sel   = head[gnt];

  always_comb begin
    pop = '0;
    if (grant) pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      out_valid    <= 1'b0;
      out_ch_id    <= '0;
      out_is_write <= 1'b0;
      out_address  <= '0;
      out_data     <= '0;
      ch_overflow  <= '0;
      ch_collision <= '0;
      record_count <= '0;
    end else begin
      case (state)
        ST_IDLE:    if (cfg_enable) state <= ST_CAPTURE;
        ST_CAPTURE: if (!cfg_enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (cfg_enable)                state <= ST_CAPTURE;
          else if (&empty && !out_valid) state <= ST_IDLE;
        end
        default:    state <= ST_IDLE;
      endcase

      if (grant) begin
        out_valid    <= 1'b1;
        out_ch_id    <= gnt;
        out_is_write <= sel.is_write;
        out_address  <= sel.address;
        out_data     <= sel.data;
        rr_ptr       <= (gnt == CH_ID_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A same-cycle set or delivery wins over clear_status.
      ch_overflow  <= (clear_status ? '0 : ch_overflow) | ovf_set;
      ch_collision <= (clear_status ? '0 : ch_collision) | col_set;
      record_count <= (clear_status ? 32'd0 : record_count) + {31'd0, deliver};
    end
  end

endmodule

// File: tb/tb_dma2mem_capture_arb.sv
// Directed bench: fairness, latency, overflow, collision/read mode, drain, reset.
module tb_dma2mem_capture_arb;
  import dma2mem_capture_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              reset_poweron, cfg_enable, cfg_capture_reads, clear_status;
  logic [NCH-1:0]    ch_write_valid, ch_write_ready, ch_read_valid, ch_read_ready;
  logic [NCH*AW-1:0] ch_write_address, ch_read_address;
  logic [NCH*DW-1:0] ch_write_data;
  logic              out_valid, out_ready, out_is_write, drained;
  logic [1:0]        out_ch_id;
  logic [AW-1:0]     out_address;
  logic [DW-1:0]     out_data;
  logic [NCH-1:0]    ch_overflow, ch_collision;
  logic [31:0]       record_count;

  int total = 0;
  int bad   = 0;

  dma2mem_capture_arb #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_poweron(reset_poweron), .cfg_enable(cfg_enable),
    .cfg_capture_reads(cfg_capture_reads), .clear_status(clear_status),
    .ch_write_valid(ch_write_valid), .ch_write_ready(ch_write_ready),
    .ch_write_address(ch_write_address), .ch_write_data(ch_write_data),
    .ch_read_valid(ch_read_valid), .ch_read_ready(ch_read_ready),
    .ch_read_address(ch_read_address), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch_id(out_ch_id), .out_is_write(out_is_write), .out_address(out_address),
    .out_data(out_data), .ch_overflow(ch_overflow), .ch_collision(ch_collision),
    .record_count(record_count), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] id, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    capture_rec_t e, o;
    e = '{ch_id: id, is_write: w, address: a, data: d};
    o = '{ch_id: out_ch_id, is_write: out_is_write, address: out_address, data: out_data};
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(o), 64'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_write_valid[c]             = 1'b1;
    ch_write_address[c*AW +: AW]  = a;
    ch_write_data[c*DW +: DW]     = d;
  endtask

  task automatic rd(input int c, input logic [AW-1:0] a);
    ch_read_valid[c]             = 1'b1;
    ch_read_address[c*AW +: AW]  = a;
  endtask

  task automatic idle_ch();
    ch_write_valid = '0;
    ch_read_valid  = '0;
  endtask

  initial begin
    reset_poweron = 1'b0; cfg_enable = 1'b0; cfg_capture_reads = 1'b0; clear_status = 1'b0;
    ch_write_valid = '0; ch_write_ready = '1; ch_read_valid = '0; ch_read_ready = '1;
    ch_write_address = '0; ch_write_data = '0; ch_read_address = '0; out_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_drained", 64'(drained), 64'd1);
    chk("rst_count", 64'(record_count), 64'd0);
    chk("rst_ovf", 64'(ch_overflow), 64'd0);
    chk("rst_col", 64'(ch_collision), 64'd0);

    reset_poweron = 1'b1; cfg_enable = 1'b1; out_ready = 1'b1;
    step();
    chk("capture_drained", 64'(drained), 64'd0);

    // Fairness: two rounds of simultaneous writes on all channels
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) wr(c, AW'(24'h000010 * c + r), DW'(32'h100 * r + c));
      step();
      idle_ch();
      for (int c = 0; c < NCH; c++) begin
        step();
        chk_rec($sformatf("rr%0d_ch%0d", r, c), 2'(c), 1'b1, AW'(24'h000010 * c + r), DW'(32'h100 * r + c));
      end
      step();
      chk($sformatf("rr%0d_empty", r), 64'(out_valid), 64'd0);
    end
    chk("rr_count", 64'(record_count), 64'd8);

    // Single write latency: event cycle N, out_valid at N+2
    wr(2, 24'h000100, 32'hDEADBEEF);
    step();
    idle_ch();
    chk("lat_n1", 64'(out_valid), 64'd0);
    step();
    chk_rec("single", 2'd2, 1'b1, 24'h000100, 32'hDEADBEEF);
    step();
    chk("single_done", 64'(out_valid), 64'd0);
    chk("single_count", 64'(record_count), 64'd9);

    // Overflow: 1 in output + 4 in FIFO, sixth write dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(1, AW'(24'h000200 + i), DW'(i));
      step();
      if (i == 4) chk("ovf_not_yet", 64'(ch_overflow), 64'd0);
    end
    idle_ch();
    chk("ovf_flag", 64'(ch_overflow), 64'b0010);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_rec($sformatf("ovf_rec%0d", i), 2'd1, 1'b1, AW'(24'h000200 + i), DW'(i));
      step();
    end
    chk("ovf_only5", 64'(out_valid), 64'd0);
    chk("ovf_count", 64'(record_count), 64'd14);

    // Collision: write wins over same-cycle read
    cfg_capture_reads = 1'b1;
    wr(0, 24'h000300, 32'hA5A5A5A5);
    rd(0, 24'h000310);
    step();
    idle_ch();
    chk("col_flag", 64'(ch_collision), 64'b0001);
    step();
    chk_rec("col_rec", 2'd0, 1'b1, 24'h000300, 32'hA5A5A5A5);
    step();
    chk("col_single", 64'(out_valid), 64'd0);

    // Lone read record
    rd(3, 24'h000400);
    step();
    idle_ch();
    step();
    chk_rec("read_rec", 2'd3, 1'b0, 24'h000400, 32'h0);
    step();
    chk("read_done", 64'(out_valid), 64'd0);

    // Reads ignored when not enabled
    cfg_capture_reads = 1'b0;
    rd(3, 24'h000404);
    step();
    idle_ch();
    step(); step();
    chk("noread_valid", 64'(out_valid), 64'd0);
    chk("noread_count", 64'(record_count), 64'd16);

    // clear_status with a same-cycle delivery
    wr(1, 24'h000333, 32'h33);
    step();
    idle_ch();
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("clr_count", 64'(record_count), 64'd1);
    chk("clr_ovf", 64'(ch_overflow), 64'd0);
    chk("clr_col", 64'(ch_collision), 64'd0);

    // Drain: three queued records, pointer at ch2 so order is 2,0,1
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) wr(c, AW'(24'h000500 + c), DW'(32'h50 + c));
    step();
    idle_ch();
    step();
    cfg_enable = 1'b0;
    step();
    wr(3, 24'h000600, 32'h60);
    step();
    idle_ch();
    chk("drain_busy", 64'(drained), 64'd0);
    out_ready = 1'b1;
    chk_rec("drain_r0", 2'd2, 1'b1, 24'h000502, 32'h52);
    step();
    chk_rec("drain_r1", 2'd0, 1'b1, 24'h000500, 32'h50);
    step();
    chk_rec("drain_r2", 2'd1, 1'b1, 24'h000501, 32'h51);
    step();
    chk("drain_last_valid", 64'(out_valid), 64'd0);
    chk("drain_not_yet", 64'(drained), 64'd0);
    step();
    chk("drain_done", 64'(drained), 64'd1);
    chk("drain_ignored", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(record_count), 64'd4);

    // Reset mid-stream discards output and FIFO contents
    cfg_enable = 1'b1; out_ready = 1'b0;
    step();
    cfg_capture_reads = 1'b1;
    wr(0, 24'h000700, 32'h70);
    rd(0, 24'h000710);
    wr(1, 24'h000701, 32'h71);
    step();
    idle_ch();
    step();
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_col", 64'(ch_collision), 64'b0001);
    reset_poweron = 1'b0;
    step();
    reset_poweron = 1'b1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_drained", 64'(drained), 64'd1);
    chk("mrst_col", 64'(ch_collision), 64'd0);
    chk("mrst_count", 64'(record_count), 64'd0);
    step(); step();
    chk("mrst_discard", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
